// File: rtl/wh_switch_allocator_if.sv
// Handshake and crossbar-select bundle between the router's input buffers,
// the switch allocator and the output links.
interface wh_switch_allocator_if #(
  parameter int IN_N       = 5,
  parameter int OUT_N      = 5,
  parameter int IN_N_W     = 3,
  parameter int OUTPUT_N_W = 3
);
  logic [IN_N-1:0]            in_valid_i;
  logic [IN_N-1:0]            in_head_i;
  logic [IN_N-1:0]            in_tail_i;
  logic [IN_N*OUTPUT_N_W-1:0] in_sel_i;
  logic [OUT_N-1:0]           out_ready_i;
  logic [IN_N-1:0]            in_ready_o;
  logic [OUT_N-1:0]           out_valid_o;
  logic [OUT_N*IN_N_W-1:0]    xbar_sel_o;
  logic [OUT_N-1:0]           out_busy_o;

  // Router side: presents flits and downstream readiness
  modport master (
    output in_valid_i, in_head_i, in_tail_i, in_sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, xbar_sel_o, out_busy_o
  );

  // Allocator side
  modport slave (
    input  in_valid_i, in_head_i, in_tail_i, in_sel_i, out_ready_i,
    output in_ready_o, out_valid_o, xbar_sel_o, out_busy_o
  );
endinterface

// File: rtl/wh_switch_allocator.sv
// Wormhole switch allocator: each output port has a round-robin arbiter that
// binds it to one input from a head flit until that packet's tail transfers.
// Crossbar selects and busy flags come from registers; valid/ready paths
// through a locked connection are combinational.
module wh_switch_allocator #(
  parameter int IN_N       = 5,
  parameter int OUT_N      = 5,
  parameter int IN_N_W     = 3,
  parameter int OUTPUT_N_W = 3
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  wh_switch_allocator_if.slave  bus
);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            r_state    [OUT_N];
  state_t            w_stateNxt [OUT_N];
  logic [IN_N_W-1:0] r_owner    [OUT_N];
  logic [IN_N_W-1:0] w_ownerNxt [OUT_N];
  logic [IN_N_W-1:0] r_rrPtr    [OUT_N];
  logic [IN_N_W-1:0] w_rrPtrNxt [OUT_N];

  logic [IN_N-1:0]   w_ownsAny;
  logic [IN_N-1:0]   w_req      [OUT_N];
  logic [OUT_N-1:0]  w_ownerValid;
  logic [OUT_N-1:0]  w_ownerTail;
  logic [OUT_N-1:0]  w_xfer;

  // Mark every input that currently holds an output; those cannot request again
  always_comb begin
    w_ownsAny = '0;
    for (int o = 0; o < OUT_N; o++) begin
      for (int i = 0; i < IN_N; i++) begin
        if (r_state[o] == LOCKED && int'(r_owner[o]) == i) begin
          w_ownsAny[i] = 1'b1;
        end
      end
    end
  end

  // Head flits from unbound inputs request the output named by their route;
  // an ID outside 0..OUT_N-1 matches nothing and simply never gets served
  always_comb begin
    for (int o = 0; o < OUT_N; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < IN_N; i++) begin
        if (bus.in_valid_i[i] && bus.in_head_i[i] && !w_ownsAny[i] &&
            int'(bus.in_sel_i[i*OUTPUT_N_W +: OUTPUT_N_W]) == o) begin
          w_req[o][i] = 1'b1;
        end
      end
    end
  end

  // Pick up the owner's valid and tail flags for each output
  always_comb begin
    w_ownerValid = '0;
    w_ownerTail  = '0;
    for (int o = 0; o < OUT_N; o++) begin
      for (int i = 0; i < IN_N; i++) begin
        if (int'(r_owner[o]) == i) begin
          w_ownerValid[o] = bus.in_valid_i[i];
          w_ownerTail[o]  = bus.in_tail_i[i];
        end
      end
    end
  end

  // Drive crossbar selects and the handshake through locked connections only
  always_comb begin
    bus.out_valid_o = '0;
    bus.xbar_sel_o  = '0;
    bus.out_busy_o  = '0;
    bus.in_ready_o  = '0;
    for (int o = 0; o < OUT_N; o++) begin
      if (r_state[o] == LOCKED) begin
        bus.out_busy_o[o]                      = 1'b1;
        bus.xbar_sel_o[o*IN_N_W +: IN_N_W]     = r_owner[o];
        bus.out_valid_o[o]                     = w_ownerValid[o];
        for (int i = 0; i < IN_N; i++) begin
          if (int'(r_owner[o]) == i) begin
            bus.in_ready_o[i] = bus.out_ready_i[o];
          end
        end
      end
    end
  end

  assign w_xfer = bus.out_valid_o & bus.out_ready_i;

  // Per-output arbitration and release: grant scans upward from the pointer,
  // release moves the pointer just past the departing owner
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int o = 0; o < OUT_N; o++) begin
      w_stateNxt[o] = r_state[o];
      w_ownerNxt[o] = r_owner[o];
      w_rrPtrNxt[o] = r_rrPtr[o];
      found         = 1'b0;
      case (r_state[o])
        FREE: begin
          if (|w_req[o]) begin
            for (int k = 0; k < IN_N; k++) begin
              idx = int'(r_rrPtr[o]) + k;
              if (idx >= IN_N) begin
                idx = idx - IN_N;
              end
              if (!found && w_req[o][idx]) begin
                found         = 1'b1;
                w_ownerNxt[o] = IN_N_W'(idx);
              end
            end
            w_stateNxt[o] = LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer[o] && w_ownerTail[o]) begin
            w_stateNxt[o] = FREE;
            w_rrPtrNxt[o] = (int'(r_owner[o]) == IN_N - 1) ? '0
                                                          : r_owner[o] + IN_N_W'(1);
          end
        end
        default: begin
          w_stateNxt[o] = FREE;
        end
      endcase
    end
  end

  // State registers; reset drops every lock at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int o = 0; o < OUT_N; o++) begin
        r_state[o] <= FREE;
        r_owner[o] <= '0;
        r_rrPtr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < OUT_N; o++) begin
        r_state[o] <= w_stateNxt[o];
        r_owner[o] <= w_ownerNxt[o];
        r_rrPtr[o] <= w_rrPtrNxt[o];
      end
    end
  end

endmodule
